// File: rtl/div_pkg.sv
// Shared types, constants and sign helpers for the divider arbiter.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIX    = 3'd3,
        RESP   = 3'd4
    } div_state_e;

    localparam int W = 32;

    // Quotient reported for a zero divisor.
    localparam logic [W-1:0] DZ_QUOTIENT = '1;

    function automatic logic [W-1:0] div_neg(input logic [W-1:0] x);
        return ~x + W'(1);
    endfunction

    function automatic logic [W-1:0] div_abs(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? div_neg(x) : x;
    endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer (wrapping); the pointer moves to grant+1 on the advance strobe.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    advance_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] grant_idx_o
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (grant_idx_o == IDW'(NREQ - 1)) ? '0 : grant_idx_o + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one unsigned divider core among NREQ requesters with sign fix-up and
// divide-by-zero bypass. Define DIV_TIMEOUT_EN to add a core watchdog.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid, once raised by the producer, holds with a stable payload
// until that edge.
module div_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32
`ifdef DIV_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    input  logic [NREQ-1:0]         req_signed,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_q,
    output logic [W-1:0]            rsp_r,
    output logic                    rsp_dz,
    output logic                    rsp_err,
    input  logic                    rsp_ready,
    output logic                    core_start,
    output logic [W-1:0]            core_a,
    output logic [W-1:0]            core_b,
    input  logic                    core_done,
    input  logic [W-1:0]            core_q,
    input  logic [W-1:0]            core_r
);

    import div_pkg::*;

    localparam int IDW = $clog2(NREQ);

    div_state_e     state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   ca_q, ca_d, cb_q, cb_d;
    logic [W-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic           negq_q, negq_d, negr_q, negr_d;
    logic           dz_q, dz_d, err_q, err_d;

`ifdef DIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            accept;
    logic [W-1:0]    a_sel, b_sel;
    logic            s_sel;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_valid),
        .advance_i  (accept),
        .grant_o    (grant),
        .grant_idx_o(gidx)
    );

    // Grants are only visible while idle, so nothing is accepted mid-operation.
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = (state_q == IDLE) && (|req_valid);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        s_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
                s_sel = req_signed[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ca_d       = ca_q;
        cb_d       = cb_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        dz_d       = dz_q;
        err_d      = err_q;
        core_start = 1'b0;
`ifdef DIV_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d   = gidx;
                    negq_d = s_sel && (a_sel[W-1] != b_sel[W-1]);
                    negr_d = s_sel && a_sel[W-1];
                    dz_d   = 1'b0;
                    err_d  = 1'b0;
                    if (b_sel == '0) begin
                        quot_d  = DZ_QUOTIENT;
                        rem_d   = a_sel;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        ca_d    = div_abs(a_sel, s_sel);
                        cb_d    = div_abs(b_sel, s_sel);
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
`ifdef DIV_TIMEOUT_EN
                cnt_d      = '0;
`endif
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    quot_d  = core_q;
                    rem_d   = core_r;
                    state_d = FIX;
                end
`ifdef DIV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            FIX: begin
                // -2^(W-1) / -1 needs no special case: the magnitude quotient
                // is already 0x80..0 and is left un-negated.
                if (negq_q) quot_d = div_neg(quot_q);
                if (negr_q) rem_d  = div_neg(rem_q);
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
        end
    end

`ifdef DIV_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_q     = quot_q;
    assign rsp_r     = rem_q;
    assign rsp_dz    = dz_q;
    assign rsp_err   = err_q;
    assign core_a    = ca_q;
    assign core_b    = cb_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a fixed-latency divider core model.
module tb_div_arbiter;
    localparam int NREQ     = 2;
    localparam int W        = 32;
    localparam int CORE_LAT = 3;

    logic                    clk, rst;
    logic [NREQ-1:0]         req_valid, req_ready, req_signed;
    logic [NREQ*W-1:0]       req_a, req_b;
    logic                    rsp_valid, rsp_dz, rsp_err, rsp_ready;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [W-1:0]            rsp_q, rsp_r, core_a, core_b, core_q, core_r;
    logic                    core_start, core_done;

    int          total, bad;
    int          core_starts;
    logic        core_en;
    logic [W-1:0] ca_seen, cb_seen;

    div_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
        .rsp_dz(rsp_dz), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_q(core_q), .core_r(core_r)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // divider core model: done pulse CORE_LAT cycles after the start pulse
    initial begin : core_model
        int  cm_cnt;
        logic cm_pend;
        core_done = 1'b0; core_q = '0; core_r = '0;
        core_starts = 0; ca_seen = '0; cb_seen = '0;
        cm_cnt = 0; cm_pend = 1'b0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (cm_pend) begin
                if (cm_cnt == 0) begin
                    cm_pend   = 1'b0;
                    core_done = core_en;
                    core_q    = (cb_seen == '0) ? '1 : ca_seen / cb_seen;
                    core_r    = (cb_seen == '0) ? ca_seen : ca_seen % cb_seen;
                end else begin
                    cm_cnt--;
                end
            end
            if (core_start) begin
                cm_pend = 1'b1;
                cm_cnt  = CORE_LAT - 1;
                ca_seen = core_a;
                cb_seen = core_b;
                core_starts++;
            end
        end
    end

    // driver tasks
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        int  n;
        logic ok;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_signed[id]   = sgn;
        req_valid[id]    = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            #1;
            if (req_ready[id]) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        req_valid[id] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL accept req%0d: no req_ready within %0d cycles", id, n); end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, want 1", rsp_valid, n); end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({rsp_valid, rsp_dz, rsp_err, core_start} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {rsp_valid, rsp_dz, rsp_err, core_start}); end
        total++; if (rsp_q !== '0 || rsp_r !== '0) begin bad++; $display("FAIL reset_qr got q=%h r=%h want 0", rsp_q, rsp_r); end
        total++; if (core_a !== '0 || core_b !== '0) begin bad++; $display("FAIL reset_core_ops got a=%h b=%h want 0", core_a, core_b); end
        total++; if (req_ready !== '0 || rsp_id !== '0) begin bad++; $display("FAIL reset_ready_id got ready=%b id=%0d want 0", req_ready, rsp_id); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin bad++; $display("FAIL post_reset_idle got valid=%b start=%b want 0", rsp_valid, core_start); end
    endtask

    task automatic test_unsigned();
        int s0, n;
        s0 = core_starts;
        issue(0, 32'd100, 32'd7, 1'b0);
        wait_rsp(n);
        total++; if (rsp_q !== 32'd14) begin bad++; $display("FAIL u_q got=%h want=%h", rsp_q, 32'd14); end
        total++; if (rsp_r !== 32'd2) begin bad++; $display("FAIL u_r got=%h want=%h", rsp_r, 32'd2); end
        total++; if (rsp_dz !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL u_flags got dz=%b err=%b want 0", rsp_dz, rsp_err); end
        total++; if (rsp_id !== 1'd0) begin bad++; $display("FAIL u_id got=%0d want=0", rsp_id); end
        total++; if (ca_seen !== 32'd100 || cb_seen !== 32'd7) begin bad++; $display("FAIL u_core_ops got a=%0d b=%0d want 100 7", ca_seen, cb_seen); end
        ack();
        repeat (3) @(posedge clk);
        #1;
        total++; if (core_starts - s0 !== 1) begin bad++; $display("FAIL u_start_count got=%0d want=1", core_starts - s0); end
        // large unsigned operands must not be sign-conditioned
        issue(1, 32'hFFFF_FFFF, 32'h10, 1'b0);
        wait_rsp(n);
        total++; if (rsp_q !== 32'h0FFF_FFFF || rsp_r !== 32'hF) begin bad++; $display("FAIL u_big got q=%h r=%h want 0fffffff 0000000f", rsp_q, rsp_r); end
        total++; if (rsp_id !== 1'd1) begin bad++; $display("FAIL u_big_id got=%0d want=1", rsp_id); end
        ack();
    endtask

    task automatic test_signed();
        int n;
        issue(1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_rsp(n);
        total++; if (ca_seen !== 32'd7 || cb_seen !== 32'd2) begin bad++; $display("FAIL s1_core_ops got a=%h b=%h want 7 2", ca_seen, cb_seen); end
        total++; if (rsp_q !== 32'hFFFF_FFFD || rsp_r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL s1_qr got q=%h r=%h want fffffffd ffffffff", rsp_q, rsp_r); end
        total++; if (rsp_id !== 1'd1) begin bad++; $display("FAIL s1_id got=%0d want=1", rsp_id); end
        ack();
        issue(0, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_rsp(n);
        total++; if (rsp_q !== 32'hFFFF_FFFD || rsp_r !== 32'd1) begin bad++; $display("FAIL s2_qr got q=%h r=%h want fffffffd 00000001", rsp_q, rsp_r); end
        ack();
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_rsp(n);
        total++; if (rsp_q !== 32'h8000_0000 || rsp_r !== 32'd0) begin bad++; $display("FAIL s_ovf got q=%h r=%h want 80000000 00000000", rsp_q, rsp_r); end
        total++; if (rsp_dz !== 1'b0) begin bad++; $display("FAIL s_ovf_dz got=%b want=0", rsp_dz); end
        ack();
    endtask

    task automatic test_div_zero();
        int s0, n;
        s0 = core_starts;
        issue(0, 32'h1234_5678, 32'd0, 1'b0);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL dz_latency rsp_valid=%b one cycle after accept, want 1", rsp_valid); end
        total++; if (rsp_q !== 32'hFFFF_FFFF || rsp_r !== 32'h1234_5678) begin bad++; $display("FAIL dz_qr got q=%h r=%h want ffffffff 12345678", rsp_q, rsp_r); end
        total++; if (rsp_dz !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL dz_flags got dz=%b err=%b want 1 0", rsp_dz, rsp_err); end
        ack();
        issue(1, 32'hFFFF_FFFB, 32'd0, 1'b1);
        wait_rsp(n);
        total++; if (n !== 0) begin bad++; $display("FAIL dz_s_latency waited=%0d want 0", n); end
        total++; if (rsp_q !== 32'hFFFF_FFFF || rsp_r !== 32'hFFFF_FFFB || rsp_dz !== 1'b1) begin bad++; $display("FAIL dz_s got q=%h r=%h dz=%b want ffffffff fffffffb 1", rsp_q, rsp_r, rsp_dz); end
        ack();
        repeat (6) @(posedge clk);
        #1;
        total++; if (core_starts - s0 !== 0) begin bad++; $display("FAIL dz_no_start got=%0d starts want=0", core_starts - s0); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [W-1:0] eq, er, hq, hr;
        logic [$clog2(NREQ)-1:0] eid;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_a[0*W +: W] = 32'd50; req_b[0*W +: W] = 32'd5; req_signed[0] = 1'b0;
        req_a[1*W +: W] = 32'd9;  req_b[1*W +: W] = 32'd4; req_signed[1] = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            eid = (k % 2 == 0) ? 1'd0 : 1'd1;
            eq  = (k % 2 == 0) ? 32'd10 : 32'd2;
            er  = (k % 2 == 0) ? 32'd0  : 32'd1;
            wait_rsp(n);
            total++; if (rsp_id !== eid) begin bad++; $display("FAIL b2b_id op%0d got=%0d want=%0d", k, rsp_id, eid); end
            total++; if (rsp_q !== eq || rsp_r !== er) begin bad++; $display("FAIL b2b_qr op%0d got q=%0d r=%0d want %0d %0d", k, rsp_q, rsp_r, eq, er); end
            total++; if (req_ready !== '0) begin bad++; $display("FAIL b2b_no_grant op%0d req_ready=%b want 00", k, req_ready); end
            if (k == 0) begin
                hq = rsp_q; hr = rsp_r;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    total++;
                    if (rsp_valid !== 1'b1 || rsp_q !== hq || rsp_r !== hr || rsp_id !== eid) begin
                        bad++; $display("FAIL b2b_hold cycle%0d got v=%b q=%0d r=%0d id=%0d want 1 %0d %0d %0d", c, rsp_valid, rsp_q, rsp_r, rsp_id, hq, hr, eid);
                    end
                end
            end
            ack();
            if (k == 3) req_valid = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        int n, viol;
        issue(0, 32'd1000, 32'd3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({rsp_valid, core_start, rsp_dz, rsp_err} !== 4'b0) begin bad++; $display("FAIL mid_rst_flags got=%b want 0000", {rsp_valid, core_start, rsp_dz, rsp_err}); end
        total++; if (core_a !== '0 || core_b !== '0 || rsp_q !== '0 || rsp_r !== '0) begin bad++; $display("FAIL mid_rst_data got a=%h b=%h q=%h r=%h want 0", core_a, core_b, rsp_q, rsp_r); end
        rst = 1'b0;
        viol = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL mid_rst_stale_rsp got %0d valid cycles want 0", viol); end
        issue(1, 32'd21, 32'd4, 1'b0);
        wait_rsp(n);
        total++; if (rsp_q !== 32'd5 || rsp_r !== 32'd1 || rsp_id !== 1'd1) begin bad++; $display("FAIL mid_rst_next got q=%0d r=%0d id=%0d want 5 1 1", rsp_q, rsp_r, rsp_id); end
        ack();
    endtask

`ifdef DIV_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        core_en = 1'b0;
        issue(0, 32'd10, 32'd3, 1'b0);
        wait_rsp(n);
        total++; if (n !== 65) begin bad++; $display("FAIL to_latency got=%0d cycles want=65", n); end
        total++; if (rsp_err !== 1'b1 || rsp_dz !== 1'b0) begin bad++; $display("FAIL to_flags got err=%b dz=%b want 1 0", rsp_err, rsp_dz); end
        total++; if (rsp_q !== '0 || rsp_r !== '0) begin bad++; $display("FAIL to_qr got q=%h r=%h want 0", rsp_q, rsp_r); end
        core_en = 1'b1;
        ack();
        issue(1, 32'd10, 32'd3, 1'b0);
        wait_rsp(n);
        total++; if (rsp_q !== 32'd3 || rsp_r !== 32'd1 || rsp_err !== 1'b0) begin bad++; $display("FAIL to_recover got q=%0d r=%0d err=%b want 3 1 0", rsp_q, rsp_r, rsp_err); end
        ack();
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; rsp_ready = 1'b0; core_en = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_signed = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
